// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port word RAM.
// Zero-wait grants, alternating priority under contention, bounded hold per port.
module mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_wstrb,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic {PORT_CPU = 1'b0, PORT_DBG = 1'b1} port_t;

  port_t            prio;
  port_t            last_port;
  port_t            rd_port;
  port_t            grant_port;
  logic [CNT_W-1:0] hold_cnt;
  logic             rd_pending;
  logic             rd_inrange;

  logic             both_req;
  logic             force_swap;
  logic             grant_any;
  logic             other_req;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic             sel_inrange;
  logic             unused_addr_bits;

  // A port that has hit the hold limit yields to the waiting one regardless of prio.
  always_comb begin
    both_req   = cpu_req && dbg_req;
    force_swap = both_req && (hold_cnt >= CNT_W'(HOLD_MAX));
    grant_any  = !reset && (cpu_req || dbg_req);
    if (both_req) begin
      if (force_swap)
        grant_port = (last_port == PORT_CPU) ? PORT_DBG : PORT_CPU;
      else
        grant_port = prio;
    end else begin
      grant_port = dbg_req ? PORT_DBG : PORT_CPU;
    end
    other_req = (grant_port == PORT_CPU) ? dbg_req : cpu_req;
  end

  // With no grant the RAM address follows the CPU port.
  always_comb begin
    if (grant_any && grant_port == PORT_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
      sel_wstrb = dbg_wstrb;
    end else begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      sel_wstrb = cpu_wstrb;
    end
    sel_inrange = (sel_addr[31:ADDR_W+2] == '0);
  end

  assign unused_addr_bits = ^sel_addr[1:0];

  assign cpu_gnt   = grant_any && (grant_port == PORT_CPU);
  assign dbg_gnt   = grant_any && (grant_port == PORT_DBG);
  assign ram_addr  = sel_addr[ADDR_W+1:2];
  assign ram_wdata = sel_wdata;
  assign ram_wen   = (grant_any && sel_we && sel_inrange) ? sel_wstrb : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio       <= PORT_CPU;
      last_port  <= PORT_CPU;
      hold_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_port    <= PORT_CPU;
      rd_inrange <= 1'b0;
    end else begin
      rd_pending <= grant_any && !sel_we;
      if (grant_any && !sel_we) begin
        rd_port    <= grant_port;
        rd_inrange <= sel_inrange;
      end
      if (grant_any) begin
        // Priority passes to the other port only if it is actually waiting.
        prio      <= other_req ? port_t'(~grant_port) : grant_port;
        last_port <= grant_port;
        if (force_swap)
          hold_cnt <= '0;
        else if (grant_port != last_port)
          hold_cnt <= other_req ? CNT_W'(1) : '0;
        else if (other_req && hold_cnt < CNT_W'(HOLD_MAX))
          hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

  // Read data is gated by reset so a read in flight when reset hits is dropped.
  assign cpu_rvalid = !reset && rd_pending && (rd_port == PORT_CPU);
  assign dbg_rvalid = !reset && rd_pending && (rd_port == PORT_DBG);
  assign cpu_rdata  = (cpu_rvalid && rd_inrange) ? ram_rdata : 32'h0;
  assign dbg_rdata  = (dbg_rvalid && rd_inrange) ? ram_rdata : 32'h0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: word-address width of the shared RAM (15 -> 128 kB).
REQ-002 SHALL have parameter HOLD_MAX, default 4: maximum consecutive grants to one port while the other port is requesting.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_req  input  1  CPU data-port access request.
REQ-006 SHALL have port cpu_we  input  1  CPU write (1) / read (0).
REQ-007 SHALL have port cpu_addr  input  32  CPU byte address.
REQ-008 SHALL have port cpu_wdata  input  32  CPU write data.
REQ-009 SHALL have port cpu_wstrb  input  4  CPU byte write enables.
REQ-010 SHALL have port cpu_gnt  output  1  CPU request accepted this cycle.
REQ-011 SHALL have port cpu_rvalid  output  1  CPU read data valid.
REQ-012 SHALL have port cpu_rdata  output  32  CPU read data.
REQ-013 SHALL have port dbg_req  input  1  debug/loader port request.
REQ-014 SHALL have port dbg_we  input  1  debug write (1) / read (0).
REQ-015 SHALL have port dbg_addr  input  32  debug byte address.
REQ-016 SHALL have port dbg_wdata  input  32  debug write data.
REQ-017 SHALL have port dbg_wstrb  input  4  debug byte write enables.
REQ-018 SHALL have port dbg_gnt  output  1  debug request accepted this cycle.
REQ-019 SHALL have port dbg_rvalid  output  1  debug read data valid.
REQ-020 SHALL have port dbg_rdata  output  32  debug read data.
REQ-021 SHALL have port ram_wen  output  4  per-byte write enable to single-port RAM.
REQ-022 SHALL have port ram_addr  output  ADDR_W  RAM word address.
REQ-023 SHALL have port ram_wdata  output  32  RAM write data.
REQ-024 SHALL have port ram_rdata  input  32  RAM read data, valid one cycle after address.

Function
REQ-025 SHALL grant at most one port per cycle; gnt combinational from req and registered arbitration state; transfer occurs when req && gnt.
REQ-026 SHALL, with a single requester, grant it in the same cycle (zero-wait).
REQ-027 SHALL, with both requesting, grant the port holding priority; priority pointer (reset: CPU) moves to the other port after each grant unless that port is not requesting.
REQ-028 SHALL count consecutive grants to one port while the other requests (hold counter, saturating at HOLD_MAX); at HOLD_MAX, force the next grant to the waiting port, then clear the counter.
REQ-029 SHALL drive ram_addr = granted addr[ADDR_W+1:2], ram_wdata = granted wdata, ram_wen = granted wstrb on a granted write, else 4'b0000.
REQ-030 SHALL treat addresses with addr[31:ADDR_W+2] != 0 as out of range: grant normally, ram_wen = 0, read returns 32'h0.
REQ-031 SHALL register read owner and in-range flag on a granted read; next cycle assert that port's rvalid for exactly one cycle, rdata = ram_rdata (or 0 if out of range), other port rvalid = 0.
REQ-032 SHALL allow back-to-back reads (one per cycle, either port) with no bubbles; rvalid order matches grant order.
REQ-033 SHALL drive ram_addr from the CPU port when nothing is granted; ram_wen = 0.
REQ-034 SHALL ignore wstrb on reads; write with wstrb = 0 is granted with no RAM change; writes produce no rvalid.

Reset
REQ-035 SHALL, while reset = 1, force cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid = 0, ram_wen = 0, rdata outputs = 0, priority = CPU, hold counter = 0.
REQ-036 SHALL drop any read accepted in the cycle reset asserts: no rvalid after reset deasserts.

Verification
REQ-037 SHALL pass: CPU write addr 100, data 25, wstrb F, dbg idle -> same cycle cpu_gnt = 1, ram_addr = 25, ram_wen = F, ram_wdata = 25.
REQ-038 SHALL pass: both request writes continuously after reset -> grants alternate CPU, dbg, CPU, dbg; no cycle with both gnt.
REQ-039 SHALL pass: dbg read addr 96, RAM word 24 = 32'hDEADBEEF -> next cycle dbg_rvalid = 1, dbg_rdata = DEADBEEF, cpu_rvalid = 0.
REQ-040 SHALL pass: write to addr 32'h0002_0000 -> gnt = 1, ram_wen = 0; read same addr -> rvalid next cycle, rdata = 0.
REQ-041 SHALL pass: HOLD_MAX = 2, dbg req held, priority pointer forced to CPU each cycle by dbg deassert pattern -> dbg granted no later than third contended cycle.
REQ-042 SHALL pass: reset asserted the cycle after a granted CPU read -> cpu_rvalid stays 0, all outputs at reset values.
